// File: rtl/rca_pkg.sv
// Shared adder result definitions: datapath width, FIFO entry layout and the
// signed-overflow helper used by the adder capture stage and ALU flag logic.
package rca_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SUM_LSB = 0;
  localparam int unsigned Z_BIT   = WIDTH;
  localparam int unsigned N_BIT   = WIDTH + 1;
  localparam int unsigned C_BIT   = WIDTH + 2;
  localparam int unsigned V_BIT   = WIDTH + 3;
  localparam int unsigned ENTRY_W = WIDTH + 4;

  // Two's-complement overflow: same-signed operands producing a differently signed sum.
  function automatic logic calc_v(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count; head data reads as zero when empty.
// Storage is not reset, only the pointers and count.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Guard against overrun/underrun even if the caller does not gate.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/rca32_result_fifo.sv
// Capture stage for the 32-bit ripple-carry adder: derives Z/N/C/V, buffers
// {sum, flags} in a small FIFO and counts accepted signed-overflow results.
module rca32_result_fifo
  import rca_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic                     in_co,
  input  logic                     in_a_msb,
  input  logic                     in_b_msb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_z,
  output logic                     out_n,
  output logic                     out_c,
  output logic                     out_v,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         ovf_cnt
);

  logic [ENTRY_W-1:0] wr_entry_c;
  logic [ENTRY_W-1:0] rd_entry_c;
  logic               full_c, empty_c;
  logic               push_c, pop_c, v_c;
  logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

  assign in_ready  = !full_c;
  assign out_valid = !empty_c;
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;
  assign v_c       = calc_v(in_a_msb, in_b_msb, in_sum[WIDTH-1]);

  // Pack the entry from the live adder inputs.
  always_comb begin
    wr_entry_c                        = '0;
    wr_entry_c[SUM_LSB +: WIDTH]      = in_sum;
    wr_entry_c[Z_BIT]                 = (in_sum == '0);
    wr_entry_c[N_BIT]                 = in_sum[WIDTH-1];
    wr_entry_c[C_BIT]                 = in_co;
    wr_entry_c[V_BIT]                 = v_c;
  end

  sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (wr_entry_c),
    .rd_data (rd_entry_c),
    .full    (full_c),
    .empty   (empty_c),
    .count   (count)
  );

  assign out_sum = rd_entry_c[SUM_LSB +: WIDTH];
  assign out_z   = rd_entry_c[Z_BIT];
  assign out_n   = rd_entry_c[N_BIT];
  assign out_c   = rd_entry_c[C_BIT];
  assign out_v   = rd_entry_c[V_BIT];

  // Saturating count of accepted overflow results.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (push_c && v_c && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_cnt_q <= '0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_rca32_result_fifo.sv
// Scoreboard bench for rca32_result_fifo: directed pushes queue hand-computed
// entries; a monitor checks the head every cycle and pops on handshake.
module tb_rca32_result_fifo;

  typedef struct packed {
    logic [31:0] sum;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_sum = '0;
  logic        in_co = 1'b0;
  logic        in_a_msb = 1'b0;
  logic        in_b_msb = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_z, out_n, out_c, out_v;
  logic [2:0]  count;
  logic [3:0]  ovf_cnt;

  exp_t q[$];
  exp_t pend;
  int   n_err = 0;
  int   n_chk = 0;
  int   exp_ovf = 0;
  bit   mon_on = 1'b0;

  always #5 clk = ~clk;

  rca32_result_fifo #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_co(in_co), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v),
    .count(count), .ovf_cnt(ovf_cnt)
  );

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock; queue the pending expectation if the DUT accepted the push.
  task automatic cycle();
    bit acc;
    @(negedge clk);
    acc = in_valid && in_ready && !reset;
    @(posedge clk);
    #1;
    if (acc) begin
      q.push_back(pend);
      if (pend.v && exp_ovf < 15) exp_ovf++;
    end
  endtask

  task automatic set_in(input logic [31:0] s, input logic co, input logic am, input logic bm,
                        input logic z, input logic n, input logic c, input logic v);
    in_valid = 1'b1; in_sum = s; in_co = co; in_a_msb = am; in_b_msb = bm;
    pend = '{sum: s, z: z, n: n, c: c, v: v};
  endtask

  task automatic push1(input logic [31:0] s, input logic co, input logic am, input logic bm,
                       input logic z, input logic n, input logic c, input logic v);
    set_in(s, co, am, bm, z, n, c, v);
    cycle();
    in_valid = 1'b0;
  endtask

  // Monitor: head must match the scoreboard front whenever valid; zeros when empty.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && !reset) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", 36'(out_valid), 36'(0));
          end else begin
            chk("head", {out_sum, out_z, out_n, out_c, out_v},
                {q[0].sum, q[0].z, q[0].n, q[0].c, q[0].v});
            if (out_ready) void'(q.pop_front());
          end
        end else begin
          chk("missing_valid", 36'(q.size()), 36'(0));
          chk("empty_head_zero", {out_sum, out_z, out_n, out_c, out_v}, 36'(0));
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    repeat (3) cycle();
    reset = 1'b0;
    mon_on = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_valid", 36'(out_valid), 36'(0));
      chk("idle_ready", 36'(in_ready), 36'(1));
      chk("idle_count", 36'(count), 36'(0));
      chk("idle_ovf", 36'(ovf_cnt), 36'(0));
    end

    // Single push: 0x80000000 + 0x80000000
    out_ready = 1'b1;
    push1(32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("single_valid", 36'(out_valid), 36'(1));
    chk("single_count", 36'(count), 36'(1));
    chk("single_ovf", 36'(ovf_cnt), 36'(1));
    cycle();

    // Fill to full, reject a fifth, then drain in order
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push1(32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_ready", 36'(in_ready), 36'(0));
    chk("full_count", 36'(count), 36'(4));
    push1(32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_reject_count", 36'(count), 36'(4));
    chk("full_reject_q", 36'(q.size()), 36'(4));
    out_ready = 1'b1;
    repeat (5) cycle();
    chk("drained_count", 36'(count), 36'(0));
    chk("drained_valid", 36'(out_valid), 36'(0));

    // Steady push+pop at occupancy 2
    out_ready = 1'b0;
    push1(32'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push1(32'd101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(32'(102 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("stream_count", 36'(count), 36'(2));
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("stream_drained", 36'(count), 36'(0));

    // Positive overflow 0x7FFFFFFF+1, then 0xFFFFFFFF+1
    push1(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("posovf_ovf", 36'(ovf_cnt), 36'(2));
    push1(32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("wrap_ovf", 36'(ovf_cnt), 36'(2));
    repeat (2) cycle();

    // Reset with three entries while both sides are active
    out_ready = 1'b0;
    for (int i = 7; i <= 9; i++) push1(32'(i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("pre_reset_count", 36'(count), 36'(3));
    chk("pre_reset_ovf", 36'(ovf_cnt), 36'(5));
    out_ready = 1'b1;
    set_in(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    q.delete();
    exp_ovf = 0;
    chk("post_reset_count", 36'(count), 36'(0));
    chk("post_reset_valid", 36'(out_valid), 36'(0));
    chk("post_reset_ovf", 36'(ovf_cnt), 36'(0));
    push1(32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_push_valid", 36'(out_valid), 36'(1));
    chk("post_reset_push_count", 36'(count), 36'(1));
    cycle();

    // ovf_cnt saturation with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      push1(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("sat_ovf", 36'(ovf_cnt), 36'(exp_ovf));
    end
    chk("sat_final", 36'(ovf_cnt), 36'(15));

    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 20) begin
      cycle();
      wait_cnt++;
    end
    chk("scoreboard_empty", 36'(q.size()), 36'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
